// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the ALU operand/result bus and the
// response/statistics outputs of alu_arbiter. The arbiter uses the slave
// modport; a client (or testbench) driving the requests uses the master one.
interface alu_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int INST_W = 3,
    parameter int OUT_W  = 16
);
    // Requester 0 channel
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [INST_W-1:0] req0_inst_i;

    // Requester 1 channel
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic [INST_W-1:0] req1_inst_i;

    // Shared ALU bus
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [INST_W-1:0] alu_inst_o;
    logic [OUT_W-1:0]  alu_data_i;

    // Responses and statistics
    logic              rsp0_valid_o;
    logic              rsp1_valid_o;
    logic [OUT_W-1:0]  rsp_data_o;
    logic [15:0]       issue_cnt_o;

    // Arbiter side
    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_inst_i,
        output req0_ready_o,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_inst_i,
        output req1_ready_o,
        output alu_a_o, alu_b_o, alu_inst_o,
        input  alu_data_i,
        output rsp0_valid_o, rsp1_valid_o, rsp_data_o, issue_cnt_o
    );

    // Client / environment side
    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_inst_i,
        input  req0_ready_o,
        output req1_valid_i, req1_a_i, req1_b_i, req1_inst_i,
        input  req1_ready_o,
        input  alu_a_o, alu_b_o, alu_inst_o,
        output alu_data_i,
        input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, issue_cnt_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. A granted
// request is registered onto the ALU inputs; a tag pipeline ALU_LAT deep
// follows each operation through the ALU and, when it falls out of the last
// stage, the ALU result is registered and pulsed to the owning requester.
module alu_arbiter #(
    parameter int DATA_W  = 8,
    parameter int INST_W  = 3,
    parameter int OUT_W   = 16,
    parameter int ALU_LAT = 2
) (
    input  logic          clk_p_i,
    input  logic          reset_p_i,
    alu_arbiter_if.slave  bus
);

    localparam int LAST = ALU_LAT - 1;

    // Which requester wins when both are valid
    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    prio_e              prio_q, prio_d;

    logic               grant0;
    logic               grant1;
    logic               issue;

    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [INST_W-1:0]  alu_inst_q, alu_inst_d;

    // Tag pipeline: bit i of tag_vld/tag_id describes the operation i+1
    // cycles into the ALU; tag_id = 1 means requester 1 owns it.
    logic [ALU_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ALU_LAT-1:0] tag_id_q, tag_id_d;

    logic               retire;
    logic               rsp0_q, rsp0_d;
    logic               rsp1_q, rsp1_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic [15:0]        cnt_q, cnt_d;

    // Round-robin grant; nothing is granted while reset is asserted
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset_p_i) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                grant0 = (prio_q == PRIO_REQ0);
                grant1 = (prio_q == PRIO_REQ1);
            end else begin
                grant0 = bus.req0_valid_i;
                grant1 = bus.req1_valid_i;
            end
        end
        issue = grant0 | grant1;
        // Whoever was just served loses priority to the other requester
        prio_d = prio_q;
        if (grant0) begin
            prio_d = PRIO_REQ1;
        end else if (grant1) begin
            prio_d = PRIO_REQ0;
        end
    end

    // Next-state for operand registers, tag pipeline, response and counter
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_inst_d = alu_inst_q;
        if (grant1) begin
            alu_a_d    = bus.req1_a_i;
            alu_b_d    = bus.req1_b_i;
            alu_inst_d = bus.req1_inst_i;
        end else if (grant0) begin
            alu_a_d    = bus.req0_a_i;
            alu_b_d    = bus.req0_b_i;
            alu_inst_d = bus.req0_inst_i;
        end

        // Stage 0 takes this cycle's issue (or a bubble); others shift on
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant1;
        for (int i = 1; i < ALU_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        // The last stage lines up with valid ALU data for that operation
        retire     = tag_vld_q[LAST];
        rsp0_d     = retire && !tag_id_q[LAST];
        rsp1_d     = retire &&  tag_id_q[LAST];
        rsp_data_d = retire ? bus.alu_data_i : rsp_data_q;

        cnt_d = cnt_q + 16'(issue);
    end

    // State registers; reset also flushes in-flight tags
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            prio_q     <= PRIO_REQ0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_inst_q <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            prio_q     <= prio_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_inst_q <= alu_inst_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.alu_a_o      = alu_a_q;
    assign bus.alu_b_o      = alu_b_q;
    assign bus.alu_inst_o   = alu_inst_q;
    assign bus.rsp0_valid_o = rsp0_q;
    assign bus.rsp1_valid_o = rsp1_q;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.issue_cnt_o  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered behavioural ALU model.
module tb_alu_arbiter;

    localparam int DATA_W  = 8;
    localparam int INST_W  = 3;
    localparam int OUT_W   = 16;
    localparam int ALU_LAT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DATA_W), .INST_W(INST_W), .OUT_W(OUT_W)) bus ();

    alu_arbiter #(
        .DATA_W (DATA_W),
        .INST_W (INST_W),
        .OUT_W  (OUT_W),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk_p_i  (clk),
        .reset_p_i(rst),
        .bus      (bus)
    );

    // ALU opcodes: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 concat, 7 zero
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return {a, b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU: one register stage after the arbiter's registered operands
    always @(posedge clk) bus.alu_data_i <= alu_f(bus.alu_a_o, bus.alu_b_o, bus.alu_inst_o);

    int checks = 0;
    int errors = 0;

    // Expected-response shift: index 2 is what must appear this cycle
    logic        sh_v [3];
    logic        sh_id[3];
    logic [15:0] sh_d [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sh();
        for (int i = 0; i < 3; i++) begin
            sh_v[i]  = 1'b0;
            sh_id[i] = 1'b0;
            sh_d[i]  = 16'h0;
        end
    endtask

    // One clock cycle with current inputs: check grants and responses at the
    // falling edge, then record the expected response of any issue.
    task automatic cyc(input logic e0, input logic e1);
        logic [15:0] d;
        @(negedge clk);
        chk("ready0", 32'(bus.req0_ready_o), 32'(e0));
        chk("ready1", 32'(bus.req1_ready_o), 32'(e1));
        chk("rsp0_valid", 32'(bus.rsp0_valid_o), 32'(sh_v[2] && !sh_id[2]));
        chk("rsp1_valid", 32'(bus.rsp1_valid_o), 32'(sh_v[2] && sh_id[2]));
        if (sh_v[2]) chk("rsp_data", 32'(bus.rsp_data_o), 32'(sh_d[2]));
        d = e1 ? alu_f(bus.req1_a_i, bus.req1_b_i, bus.req1_inst_i)
               : alu_f(bus.req0_a_i, bus.req0_b_i, bus.req0_inst_i);
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            sh_v[i]  = sh_v[i-1];
            sh_id[i] = sh_id[i-1];
            sh_d[i]  = sh_d[i-1];
        end
        sh_v[0]  = e0 | e1;
        sh_id[0] = e1;
        sh_d[0]  = d;
    endtask

    initial begin
        rst              = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req0_a_i     = '0;
        bus.req0_b_i     = '0;
        bus.req0_inst_i  = '0;
        bus.req1_valid_i = 1'b0;
        bus.req1_a_i     = '0;
        bus.req1_b_i     = '0;
        bus.req1_inst_i  = '0;
        clear_sh();

        // Reset held two cycles; a request during reset must not be granted
        @(posedge clk);
        #1;
        bus.req0_valid_i = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 32'(bus.req0_ready_o), 32'h0);
        chk("rst_ready1", 32'(bus.req1_ready_o), 32'h0);
        chk("rst_alu_a", 32'(bus.alu_a_o), 32'h0);
        chk("rst_alu_b", 32'(bus.alu_b_o), 32'h0);
        chk("rst_alu_inst", 32'(bus.alu_inst_o), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data_o), 32'h0);
        chk("rst_rsp0", 32'(bus.rsp0_valid_o), 32'h0);
        chk("rst_rsp1", 32'(bus.rsp1_valid_o), 32'h0);
        chk("rst_cnt", 32'(bus.issue_cnt_o), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_cnt_after_req", 32'(bus.issue_cnt_o), 32'h0);
        rst              = 1'b0;
        bus.req0_valid_i = 1'b0;

        // Idle: no pulses for 10 cycles
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);

        // Single requester 0: 0x12 + 0x34 = 0x0046
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 8'h12;
        bus.req0_b_i     = 8'h34;
        bus.req0_inst_i  = 3'd0;
        cyc(1'b1, 1'b0);
        bus.req0_valid_i = 1'b0;
        chk("single_alu_a", 32'(bus.alu_a_o), 32'h12);
        chk("single_alu_b", 32'(bus.alu_b_o), 32'h34);
        chk("single_alu_inst", 32'(bus.alu_inst_o), 32'h0);
        chk("single_cnt", 32'(bus.issue_cnt_o), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // Back-to-back stream from requester 1: i * (i+1)
        for (int i = 0; i < 8; i++) begin
            bus.req1_valid_i = 1'b1;
            bus.req1_a_i     = 8'(i);
            bus.req1_b_i     = 8'(i + 1);
            bus.req1_inst_i  = 3'd2;
            cyc(1'b0, 1'b1);
        end
        bus.req1_valid_i = 1'b0;
        chk("stream_cnt", 32'(bus.issue_cnt_o), 32'd9);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // Contention: requester 0 has priority after the stream; alternate
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 8'h03;
        bus.req0_b_i     = 8'h04;
        bus.req0_inst_i  = 3'd0;
        bus.req1_valid_i = 1'b1;
        bus.req1_a_i     = 8'h05;
        bus.req1_b_i     = 8'h06;
        bus.req1_inst_i  = 3'd2;
        for (int k = 0; k < 6; k++) cyc(1'((k % 2) == 0), 1'((k % 2) == 1));
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        chk("contend_cnt", 32'(bus.issue_cnt_o), 32'd15);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // Reset mid-flight: two issues, then reset the next cycle
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 8'h10;
        bus.req0_b_i     = 8'h20;
        bus.req0_inst_i  = 3'd0;
        cyc(1'b1, 1'b0);
        bus.req0_a_i     = 8'h30;
        cyc(1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready0", 32'(bus.req0_ready_o), 32'h0);
        chk("midrst_rsp0", 32'(bus.rsp0_valid_o), 32'h0);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.req0_valid_i = 1'b0;
        clear_sh();
        chk("midrst_cnt", 32'(bus.issue_cnt_o), 32'h0);
        chk("midrst_alu_a", 32'(bus.alu_a_o), 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

        // First op after reset: 5 - 7 = 0xFFFE
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 8'h05;
        bus.req0_b_i     = 8'h07;
        bus.req0_inst_i  = 3'd1;
        cyc(1'b1, 1'b0);
        bus.req0_valid_i = 1'b0;
        chk("post_rst_cnt", 32'(bus.issue_cnt_o), 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        // Counter wrap: 65535 more issues bring the count from 1 back to 0
        for (int i = 0; i < 65535; i++) begin
            bus.req1_valid_i = 1'b1;
            bus.req1_a_i     = 8'(i);
            bus.req1_b_i     = 8'(i >> 8);
            bus.req1_inst_i  = 3'(i);
            cyc(1'b0, 1'b1);
        end
        bus.req1_valid_i = 1'b0;
        chk("wrap_cnt", 32'(bus.issue_cnt_o), 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance (8-bit operands, 3-bit instruction, 16-bit registered result) between two requesters.
- Per cycle: picks at most one request by round-robin and registers its operands onto the ALU inputs.
- Tracks which requester owns each in-flight operation across the ALU latency, then returns the result as a one-cycle response pulse to that requester.
- Sits between the two datapath clients and the ALU inside the core.

Parameters:
- DATA_W, 8, operand width (matches ALU data_a_i/data_b_i).
- INST_W, 3, instruction width (matches ALU inst_i).
- OUT_W, 16, result width (matches ALU data_o).
- ALU_LAT, 2, cycles from ALU input change (registered here) to valid ALU data_o; legal range 1..4.

Ports:
- clk_p_i  in  1  clock; all state updates on the rising edge.
- reset_p_i  in  1  synchronous, active-high reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 is granted this cycle.
- req0_a_i  in  DATA_W  requester 0 operand A.
- req0_b_i  in  DATA_W  requester 0 operand B.
- req0_inst_i  in  INST_W  requester 0 instruction.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_inst_i  same as requester 0, for requester 1.
- alu_a_o  out  DATA_W  to ALU data_a_i.
- alu_b_o  out  DATA_W  to ALU data_b_i.
- alu_inst_o  out  INST_W  to ALU inst_i.
- alu_data_i  in  OUT_W  from ALU data_o.
- rsp0_valid_o  out  1  result for requester 0 on rsp_data_o.
- rsp1_valid_o  out  1  result for requester 1 on rsp_data_o.
- rsp_data_o  out  OUT_W  registered result.
- issue_cnt_o  out  16  count of issued operations.

Behaviour:
- Reset (synchronous, active-high): alu_a_o, alu_b_o, alu_inst_o, rsp_data_o, issue_cnt_o all 0. rsp0/1_valid_o 0. Tag pipeline cleared. RR pointer = requester 0 has priority.
- Handshake: a transfer happens in a cycle where reqN_valid_i && reqN_ready_o. Ready is combinational and may depend on valid; valid must not depend on ready. Once asserted, a requester holds valid and its payload stable until the transfer.
- Grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester holding priority is granted, and priority flips to the other one.
  - A single-requester grant also sets priority to the other requester.
  - Neither valid: no grant, pointer unchanged.
  - Ready is never asserted during reset.
- Issue (transfer in cycle t): at the edge ending t, alu_*_o load the granted payload. A tag entry {valid=1, id} enters stage 0 of the ALU_LAT-deep tag shift pipeline, and issue_cnt_o increments (wraps 0xFFFF->0).
- Idle cycle: alu_*_o hold their last values; a tag entry with valid=0 enters the pipeline.
- Retire: when the last tag stage is valid, at that edge rsp_data_o <= alu_data_i and rspN_valid_o <= 1 for the tagged id. Both are high for exactly that one cycle; rsp_data_o holds its value otherwise.
- Latency: handshake in cycle t -> response valid in cycle t+1+ALU_LAT (t+3 at default).
- Throughput: one operation per cycle, back-to-back. Results return in issue order. There is no response backpressure; requesters must accept the pulse.
- Simultaneous events: an issue and a retire in the same cycle are independent. Reset has priority over any handshake in the same cycle; ready is 0 in that cycle.
- Reset mid-operation: all in-flight tags are discarded and no response pulses are produced for them. The ALU result is ignored until a new issue reaches the last stage.

Test Plan:
- Reset: hold reset_p_i 2 cycles -> all outputs 0, ready low. After release, with no requests, no rsp pulse for 10 cycles.
- Single requester: req0 a=0x12, b=0x34, inst=0 (ALU add model), valid in cycle 5 -> req0_ready_o=1 in cycle 5; alu_a_o=0x12 from cycle 6; rsp0_valid_o=1 only in cycle 8 with rsp_data_o=0x0046; rsp1_valid_o stays 0; issue_cnt_o=1.
- Contention: both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. Responses alternate rsp0/rsp1 in the same order, each 3 cycles after its grant. issue_cnt_o=6.
- Back-to-back stream: req1 streams 8 ops a=i, b=i+1 with the multiply instruction -> 8 consecutive rsp1 pulses, data i*(i+1), in order, no gaps.
- Reset mid-flight: issue 2 ops, assert reset the cycle after the second issue -> no rsp pulses afterwards and issue_cnt_o=0. The next op issued after release returns normally 3 cycles later.
- Counter wrap: preload by issuing 65536 ops -> issue_cnt_o returns to 0x0000. The final response is still correct.
